sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of Avalon-MM requesters (accelerator weight read, activation read, result write).
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-004 SHALL have parameter MAX_OUT, default 8, power of two, maximum outstanding reads.
REQ-005 SHALL have ports (name direction width meaning), in this order:
clk_clk  in  1  single clock, all logic rising-edge;
reset_reset  in  1  synchronous, active-high reset;
req_read  in  N_REQ  per-requester read;
req_write  in  N_REQ  per-requester write;
req_address  in  N_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W];
req_writedata  in  N_REQ*DATA_W  packed likewise;
req_byteenable  in  N_REQ*DATA_W/8  packed likewise;
req_waitrequest  out  N_REQ  low for exactly the acceptance cycle;
req_readdata  out  DATA_W  shared read data;
req_readdatavalid  out  N_REQ  one-hot response strobe;
avm_address  out  ADDR_W;  avm_read  out  1;  avm_write  out  1;
avm_writedata  out  DATA_W;  avm_byteenable  out  DATA_W/8;
avm_waitrequest  in  1;  avm_readdata  in  DATA_W;  avm_readdatavalid  in  1;
err_orphan  out  1  sticky: response with no outstanding read.

Function
REQ-006 SHALL implement FSM IDLE/ISSUE; avm_* command outputs SHALL be registered.
REQ-007 IDLE: eligible = (req_read & read FIFO not full) | req_write; no eligible requester -> stay IDLE, avm_read=avm_write=0.
REQ-008 IDLE winner SHALL be first eligible index at or above rr_ptr, wrapping modulo N_REQ; its command is registered onto avm_*; next state ISSUE.
REQ-009 If a requester asserts read and write together, read SHALL be used, write ignored.
REQ-010 ISSUE: avm command held stable while avm_waitrequest=1; in the cycle avm_waitrequest=0, req_waitrequest[grant] SHALL be 0 (combinational), rr_ptr <= (grant+1) mod N_REQ, next state IDLE.
REQ-011 req_waitrequest SHALL be 1 for every requester in all other cycles; peak throughput is one transfer per 2 cycles.
REQ-012 An accepted read SHALL push grant index into the ID FIFO (depth MAX_OUT) in the acceptance cycle.
REQ-013 avm_readdatavalid=1 with FIFO non-empty SHALL pop the head ID and drive req_readdatavalid[head]=1, req_readdata=avm_readdata in the same cycle (zero latency, combinational).
REQ-014 Push and pop in the same cycle SHALL both take effect, count unchanged, including when full.
REQ-015 avm_readdatavalid=1 with FIFO empty SHALL drive no req_readdatavalid and set err_orphan until reset.
REQ-016 Responses SHALL return in issue order; no reordering.
REQ-017 Writes SHALL not be blocked by a full read FIFO.

Reset
REQ-018 While reset_reset=1, at next edge: state IDLE, rr_ptr=0, FIFO empty, avm_read=avm_write=0, avm_address/writedata=0, avm_byteenable=0, err_orphan=0.
REQ-019 Reset mid-ISSUE SHALL abandon the command without acceptance; req_waitrequest all 1 during reset.
REQ-020 Responses for reads issued before reset SHALL be treated as orphans (REQ-015); system resets the SDRAM controller together.

Structure
REQ-021 Shared package sdram_arb_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-022 ID FIFO SHALL be sub-module arb_id_fifo (width clog2(N_REQ), depth MAX_OUT, full/empty, simultaneous push/pop); the rest is one module.

Verification
REQ-023 Single read, req 1, address 0x100, avm_waitrequest 3 cycles: avm_read held 4 cycles, req_waitrequest[1]=0 one cycle, response 0xDEADBEEF -> req_readdatavalid=3'b010.
REQ-024 All three requesters reading continuously from reset: grants 0,1,2,0,1,2; no starvation.
REQ-025 Requester 0 issues 9 reads with responses withheld: 8 accepted, 9th stalls while requester 2 write to 0x40 is still accepted; one response releases 9th.
REQ-026 Interleaved reads 0,2,1 returned with gaps: readdatavalid one-hot 001,100,010 in order with matching data.
REQ-027 avm_readdatavalid pulse with no outstanding read -> err_orphan=1 sticky, no req_readdatavalid; reset clears it.
REQ-028 Reset asserted during ISSUE with avm_waitrequest=1 -> next cycle avm_read=0, all req_waitrequest=1, rr_ptr=0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter.
// Contents:
//   - arb_state_e : two-state command FSM (IDLE / ISSUE)
//   - DEF_*       : default parameter values used by sdram_port_arbiter
//   - id_width()  : width of a requester index (never less than 1 bit)
package sdram_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ   = 3;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MAX_OUT = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// Requester-ID FIFO for outstanding reads.
// Holds the index of each accepted read so that in-order read responses can
// be steered back to the requester that issued them.
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   push, push_id     : enqueue an ID (ignored when full unless popping too)
//   pop               : dequeue the head ID (ignored when empty)
//   head_id           : ID at the head of the queue
//   full, empty       : occupancy flags
// Push and pop in the same cycle both take effect, including when full.
module arb_id_fifo #(
  parameter int ID_W  = 2,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head_id,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter multiplexing N_REQ Avalon-MM requesters onto one
// Avalon-MM SDRAM master port.
// Ports:
//   clk_clk, reset_reset          : clock, synchronous active-high reset
//   req_read/write/address/
//   writedata/byteenable          : packed per-requester commands
//   req_waitrequest               : low only in a requester's acceptance cycle
//   req_readdata/readdatavalid    : shared read data, one-hot response strobe
//   avm_*                         : registered command to the SDRAM controller,
//                                   plus its waitrequest and read response
//   err_orphan                    : sticky, a response arrived with no read
//                                   outstanding
// One command is in flight at a time: IDLE picks a winner and registers its
// command, ISSUE holds it until the controller drops waitrequest.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic [N_REQ-1:0]           req_read,
  input  logic [N_REQ-1:0]           req_write,
  input  logic [N_REQ*ADDR_W-1:0]    req_address,
  input  logic [N_REQ*DATA_W-1:0]    req_writedata,
  input  logic [N_REQ*DATA_W/8-1:0]  req_byteenable,
  output logic [N_REQ-1:0]           req_waitrequest,
  output logic [DATA_W-1:0]          req_readdata,
  output logic [N_REQ-1:0]           req_readdatavalid,
  output logic [ADDR_W-1:0]          avm_address,
  output logic                       avm_read,
  output logic                       avm_write,
  output logic [DATA_W-1:0]          avm_writedata,
  output logic [DATA_W/8-1:0]        avm_byteenable,
  input  logic                       avm_waitrequest,
  input  logic [DATA_W-1:0]          avm_readdata,
  input  logic                       avm_readdatavalid,
  output logic                       err_orphan
);

  localparam int BE_W = DATA_W / 8;
  localparam int ID_W = id_width(N_REQ);

  arb_state_e        state;
  arb_state_e        state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant;
  logic              grant_is_read;
  logic [N_REQ-1:0]  eligible;
  logic [ID_W-1:0]   win;
  logic              win_valid;
  logic              win_is_read;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [BE_W-1:0]   win_be;
  logic              accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ID_W-1:0]   head_id;

  // A requester raising read and write together is treated as a read, so a
  // full FIFO blocks it even if its write line is also high.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_read[i] ? !fifo_full : req_write[i];
    end
  end

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    win       = '0;
    win_valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (eligible[ID_W'(idx)]) begin
        win       = ID_W'(idx);
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    win_is_read = 1'b0;
    win_addr    = '0;
    win_wdata   = '0;
    win_be      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == win) begin
        win_is_read = req_read[i];
        win_addr    = req_address[i*ADDR_W +: ADDR_W];
        win_wdata   = req_writedata[i*DATA_W +: DATA_W];
        win_be      = req_byteenable[i*BE_W +: BE_W];
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= ST_IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (win_valid)        state_next = ST_ISSUE;
      ST_ISSUE: if (!avm_waitrequest) state_next = ST_IDLE;
      default:                        state_next = ST_IDLE;
    endcase
  end

  // Reset overrides acceptance so an in-flight command is abandoned.
  always_comb begin
    accept          = (state == ST_ISSUE) && !avm_waitrequest && !reset_reset;
    req_waitrequest = '1;
    if (accept) req_waitrequest[grant] = 1'b0;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      grant          <= '0;
      grant_is_read  <= 1'b0;
      rr_ptr         <= '0;
    end else if ((state == ST_IDLE) && win_valid) begin
      avm_read       <= win_is_read;
      avm_write      <= !win_is_read;
      avm_address    <= win_addr;
      avm_writedata  <= win_wdata;
      avm_byteenable <= win_be;
      grant          <= win;
      grant_is_read  <= win_is_read;
    end else if (accept) begin
      avm_read  <= 1'b0;
      avm_write <= 1'b0;
      rr_ptr    <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
    end
  end

  assign fifo_push = accept && grant_is_read;
  assign fifo_pop  = avm_readdatavalid && !fifo_empty;

  arb_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .push    (fifo_push),
    .push_id (grant),
    .pop     (fifo_pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Responses come back in issue order, so the FIFO head names the owner.
  assign req_readdata = avm_readdata;

  always_comb begin
    req_readdatavalid = '0;
    if (fifo_pop) req_readdatavalid[head_id] = 1'b1;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset)                            err_orphan <= 1'b0;
    else if (avm_readdatavalid && fifo_empty)   err_orphan <= 1'b1;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios followed by
// a randomized run against a transaction-level reference model.
module tb_sdram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_read = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_address = '0;
  logic [N*DW-1:0] req_writedata = '0;
  logic [N*BW-1:0] req_byteenable = '0;
  logic [N-1:0]    req_waitrequest;
  logic [DW-1:0]   req_readdata;
  logic [N-1:0]    req_readdatavalid;
  logic [AW-1:0]   avm_address;
  logic            avm_read;
  logic            avm_write;
  logic [DW-1:0]   avm_writedata;
  logic [BW-1:0]   avm_byteenable;
  logic            avm_waitrequest = 1'b1;
  logic [DW-1:0]   avm_readdata = '0;
  logic            avm_readdatavalid = 1'b0;
  logic            err_orphan;

  int errors = 0;
  int checks = 0;

  // Commands currently held by each requester
  bit            p_rd [N];
  bit            p_wr [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_wd [N];
  logic [BW-1:0] m_be [N];

  sdram_port_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)
  ) dut (
    .clk_clk           (clk),
    .reset_reset       (rst),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_address       (req_address),
    .req_writedata     (req_writedata),
    .req_byteenable    (req_byteenable),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .err_orphan        (err_orphan)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_read[i]                = p_rd[i];
      req_write[i]               = p_wr[i];
      req_address[i*AW +: AW]    = m_addr[i];
      req_writedata[i*DW +: DW]  = m_wd[i];
      req_byteenable[i*BW +: BW] = m_be[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      p_rd[i] = 1'b0; p_wr[i] = 1'b0;
      m_addr[i] = '0; m_wd[i] = '0; m_be[i] = '0;
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    avm_waitrequest = 1'b1;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Waits (bounded) for requester i to see its acceptance cycle; returns at
  // posedge+1 so the caller may update that requester's command.
  task automatic wait_accept(input int i, input int budget, output bit got,
                             output logic cap_wr, output logic [AW-1:0] cap_addr);
    got = 1'b0; cap_wr = 1'b0; cap_addr = '0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (req_waitrequest[i] === 1'b0) begin
        got = 1'b1; cap_wr = avm_write; cap_addr = avm_address;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_any_accept(input int budget, output bit got, output int idx,
                                 output logic [AW-1:0] cap_addr);
    got = 1'b0; idx = -1; cap_addr = '0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req_waitrequest[i] === 1'b0) begin
          got = 1'b1; idx = i; cap_addr = avm_address;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    avm_readdatavalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({avm_read, avm_write} !== 2'b00) begin
      errors++; $display("FAIL reset_cmd: got %b required 00", {avm_read, avm_write});
    end
    checks++;
    if (avm_address !== '0 || avm_writedata !== '0 || avm_byteenable !== '0) begin
      errors++; $display("FAIL reset_bus: got addr %h wd %h be %h required zeros",
                         avm_address, avm_writedata, avm_byteenable);
    end
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++; $display("FAIL reset_orphan: got %b required 0", err_orphan);
    end
    checks++;
    if (req_waitrequest !== 3'b111 || req_readdatavalid !== 3'b000) begin
      errors++; $display("FAIL reset_req: got wait %b rdv %b required 111 000",
                         req_waitrequest, req_readdatavalid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    int high_cycles;
    high_cycles = 0;
    do_reset();
    p_rd[1] = 1'b1; m_addr[1] = 32'h100; drive();
    avm_waitrequest = 1'b1;
    @(negedge clk);
    checks++;
    if (avm_read !== 1'b0) begin
      errors++; $display("FAIL single_idle: avm_read got %b required 0", avm_read);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 3) avm_waitrequest = 1'b0;
      @(negedge clk);
      if (avm_read === 1'b1) high_cycles++;
      checks++;
      if (avm_read !== 1'b1 || avm_address !== 32'h100) begin
        errors++; $display("FAIL single_hold c=%0d: got rd %b addr %h required 1 00000100",
                           c, avm_read, avm_address);
      end
      checks++;
      if (req_waitrequest !== ((c == 3) ? 3'b101 : 3'b111)) begin
        errors++; $display("FAIL single_wait c=%0d: got %b required %b", c,
                           req_waitrequest, (c == 3) ? 3'b101 : 3'b111);
      end
    end
    @(posedge clk); #1;
    p_rd[1] = 1'b0; drive();
    avm_waitrequest = 1'b1;
    @(negedge clk);
    if (avm_read === 1'b1) high_cycles++;
    checks++;
    if (high_cycles != 4) begin
      errors++; $display("FAIL single_len: avm_read high %0d cycles required 4", high_cycles);
    end
    @(posedge clk); #1;
    avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (req_readdatavalid !== 3'b010 || req_readdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_resp: got rdv %b data %h required 010 deadbeef",
                         req_readdatavalid, req_readdata);
    end
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
  endtask

  task automatic test_fifo_full();
    bit got; logic cw; logic [AW-1:0] ca; int acc;
    do_reset();
    avm_waitrequest = 1'b0;
    acc = 0;
    p_rd[0] = 1'b1; m_addr[0] = 32'h1000; drive();
    for (int n = 0; n < MO; n++) begin
      wait_accept(0, 10, got, cw, ca);
      if (got) acc++;
      m_addr[0] = 32'h1000 + 32'(4 * (n + 1)); drive();
    end
    checks++;
    if (acc != MO) begin
      errors++; $display("FAIL full_fill: accepted %0d required %0d", acc, MO);
    end
    wait_accept(0, 10, got, cw, ca);
    checks++;
    if (got !== 1'b0) begin
      errors++; $display("FAIL full_stall: 9th read accepted %b required 0", got);
    end
    p_wr[2] = 1'b1; m_addr[2] = 32'h40; m_wd[2] = 32'h55AA; m_be[2] = 4'hF; drive();
    wait_accept(2, 10, got, cw, ca);
    checks++;
    if (got !== 1'b1 || cw !== 1'b1 || ca !== 32'h40) begin
      errors++; $display("FAIL full_write: got acc %b wr %b addr %h required 1 1 00000040",
                         got, cw, ca);
    end
    p_wr[2] = 1'b0; drive();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h11110000;
    @(negedge clk);
    checks++;
    if (req_readdatavalid !== 3'b001 || req_readdata !== 32'h11110000) begin
      errors++; $display("FAIL full_resp: got rdv %b data %h required 001 11110000",
                         req_readdatavalid, req_readdata);
    end
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    wait_accept(0, 10, got, cw, ca);
    checks++;
    if (got !== 1'b1) begin
      errors++; $display("FAIL full_release: 9th read accepted %b required 1", got);
    end
    p_rd[0] = 1'b0; drive();
    for (int n = 0; n < MO; n++) begin
      avm_readdatavalid = 1'b1; avm_readdata = 32'h2000 + 32'(n);
      @(negedge clk);
      checks++;
      if (req_readdatavalid !== 3'b001 || req_readdata !== 32'h2000 + 32'(n)) begin
        errors++; $display("FAIL full_drain n=%0d: got rdv %b data %h required 001 %h",
                           n, req_readdatavalid, req_readdata, 32'h2000 + 32'(n));
      end
      @(posedge clk); #1;
      avm_readdatavalid = 1'b0;
    end
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++; $display("FAIL full_orphan: got %b required 0", err_orphan);
    end
  endtask

  task automatic test_interleaved();
    bit got; logic cw; logic [AW-1:0] ca;
    int order [3];
    logic [DW-1:0] dat;
    order[0] = 0; order[1] = 2; order[2] = 1;
    do_reset();
    avm_waitrequest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p_rd[order[k]] = 1'b1; m_addr[order[k]] = 32'h300 + 32'(k * 16); drive();
      wait_accept(order[k], 10, got, cw, ca);
      checks++;
      if (got !== 1'b1) begin
        errors++; $display("FAIL inter_issue k=%0d: accepted %b required 1", k, got);
      end
      p_rd[order[k]] = 1'b0; drive();
    end
    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
        @(posedge clk); #1;
      end
      dat = $urandom;
      avm_readdatavalid = 1'b1; avm_readdata = dat;
      @(negedge clk);
      checks++;
      if (req_readdatavalid !== 3'(1 << order[k]) || req_readdata !== dat) begin
        errors++; $display("FAIL inter_resp k=%0d: got rdv %b data %h required %b %h",
                           k, req_readdatavalid, req_readdata, 3'(1 << order[k]), dat);
      end
      @(posedge clk); #1;
      avm_readdatavalid = 1'b0;
    end
  endtask

  task automatic test_orphan();
    do_reset();
    avm_readdatavalid = 1'b1; avm_readdata = 32'hBAD0BAD0;
    @(negedge clk);
    checks++;
    if (req_readdatavalid !== 3'b000) begin
      errors++; $display("FAIL orphan_rdv: got %b required 000", req_readdatavalid);
    end
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (err_orphan !== 1'b1) begin
        errors++; $display("FAIL orphan_sticky c=%0d: got %b required 1", c, err_orphan);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++; $display("FAIL orphan_clear: got %b required 0", err_orphan);
    end
    @(posedge clk); #1;
  endtask

  // Reset during ISSUE, then all three reading continuously from reset.
  task automatic test_reset_mid_issue();
    bit got; logic cw; logic [AW-1:0] ca; int idx;
    logic [DW-1:0] dat;
    do_reset();
    avm_waitrequest = 1'b0;
    p_wr[0] = 1'b1; m_addr[0] = 32'h40; drive();
    wait_accept(0, 10, got, cw, ca);
    p_wr[0] = 1'b0; drive();
    avm_waitrequest = 1'b1;
    p_rd[1] = 1'b1; m_addr[1] = 32'h200; drive();
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (avm_read !== 1'b1) begin
      errors++; $display("FAIL midrst_issue: avm_read got %b required 1", avm_read);
    end
    @(posedge clk); #1;
    rst = 1'b1; avm_waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if (req_waitrequest !== 3'b111) begin
      errors++; $display("FAIL midrst_wait: got %b required 111", req_waitrequest);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      p_rd[i] = 1'b1; m_addr[i] = 32'(32'h1000 * (i + 1));
    end
    drive();
    @(negedge clk);
    checks++;
    if (avm_read !== 1'b0 || req_waitrequest !== 3'b111) begin
      errors++; $display("FAIL midrst_after: got rd %b wait %b required 0 111",
                         avm_read, req_waitrequest);
    end
    @(posedge clk); #1;
    for (int n = 0; n < 6; n++) begin
      wait_any_accept(10, got, idx, ca);
      checks++;
      if (got !== 1'b1 || idx != n % N || ca !== m_addr[n % N]) begin
        errors++; $display("FAIL rr_grant n=%0d: got acc %b idx %0d addr %h required 1 %0d %h",
                           n, got, idx, ca, n % N, m_addr[n % N]);
      end
      if (idx >= 0) begin
        m_addr[idx] = m_addr[idx] + 32'h4; drive();
      end
    end
    clear_reqs();
    for (int n = 0; n < 6; n++) begin
      dat = $urandom;
      avm_readdatavalid = 1'b1; avm_readdata = dat;
      @(negedge clk);
      checks++;
      if (req_readdatavalid !== 3'(1 << (n % N)) || req_readdata !== dat) begin
        errors++; $display("FAIL rr_resp n=%0d: got rdv %b data %h required %b %h",
                           n, req_readdatavalid, req_readdata, 3'(1 << (n % N)), dat);
      end
      @(posedge clk); #1;
      avm_readdatavalid = 1'b0;
    end
  endtask

  // Reference: at most one command in flight; when free, the next owner is
  // the first requester at or after rr whose command can be taken (reads
  // need fewer than MO outstanding); reads complete in acceptance order.
  task automatic test_random();
    int q[$];
    int rr, owner, accepts, idx;
    bit busy, full_now;
    logic [N-1:0] exp_wait, exp_rdv;
    logic [DW-1:0] rdata;
    do_reset();
    rr = 0; owner = 0; busy = 1'b0; accepts = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_rd[i] && !p_wr[i] && $urandom_range(2, 0) == 0) begin
          if ($urandom_range(1, 0) == 1) p_rd[i] = 1'b1;
          else                           p_wr[i] = 1'b1;
          m_addr[i] = $urandom; m_wd[i] = $urandom;
          m_be[i] = BW'($urandom_range(15, 0));
        end
      end
      drive();
      avm_waitrequest = ($urandom_range(1, 0) == 0);
      rdata = $urandom;
      avm_readdata = rdata;
      avm_readdatavalid = (q.size() > 0) && ($urandom_range(3, 0) == 0);
      @(negedge clk);
      exp_wait = '1;
      if (busy && !avm_waitrequest) exp_wait[owner] = 1'b0;
      checks++;
      if (req_waitrequest !== exp_wait) begin
        errors++; $display("FAIL rnd_wait cyc=%0d: got %b required %b", cyc, req_waitrequest, exp_wait);
      end
      if (busy) begin
        checks++;
        if (avm_read !== p_rd[owner] || avm_write !== p_wr[owner] || avm_address !== m_addr[owner]) begin
          errors++; $display("FAIL rnd_cmd cyc=%0d: got rd %b wr %b addr %h required %b %b %h (req %0d)",
                             cyc, avm_read, avm_write, avm_address, p_rd[owner], p_wr[owner],
                             m_addr[owner], owner);
        end
        if (p_wr[owner]) begin
          checks++;
          if (avm_writedata !== m_wd[owner] || avm_byteenable !== m_be[owner]) begin
            errors++; $display("FAIL rnd_wdata cyc=%0d: got %h %h required %h %h", cyc,
                               avm_writedata, avm_byteenable, m_wd[owner], m_be[owner]);
          end
        end
      end else begin
        checks++;
        if (avm_read !== 1'b0 || avm_write !== 1'b0) begin
          errors++; $display("FAIL rnd_idle cyc=%0d: got rd %b wr %b required 0 0", cyc, avm_read, avm_write);
        end
      end
      exp_rdv = '0;
      if (avm_readdatavalid) exp_rdv[q[0]] = 1'b1;
      checks++;
      if (req_readdatavalid !== exp_rdv) begin
        errors++; $display("FAIL rnd_rdv cyc=%0d: got %b required %b", cyc, req_readdatavalid, exp_rdv);
      end
      if (avm_readdatavalid) begin
        checks++;
        if (req_readdata !== rdata) begin
          errors++; $display("FAIL rnd_rdata cyc=%0d: got %h required %h", cyc, req_readdata, rdata);
        end
      end
      checks++;
      if (err_orphan !== 1'b0) begin
        errors++; $display("FAIL rnd_orphan cyc=%0d: got %b required 0", cyc, err_orphan);
      end
      full_now = (q.size() >= MO);
      if (avm_readdatavalid) void'(q.pop_front());
      if (busy) begin
        if (!avm_waitrequest) begin
          if (p_rd[owner]) q.push_back(owner);
          rr = (owner + 1) % N;
          p_rd[owner] = 1'b0; p_wr[owner] = 1'b0;
          busy = 1'b0;
          accepts++;
        end
      end else begin
        for (int k = 0; k < N && !busy; k++) begin
          idx = (rr + k) % N;
          if (p_rd[idx] ? !full_now : p_wr[idx]) begin
            busy = 1'b1; owner = idx;
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (accepts < 200) begin
      errors++; $display("FAIL rnd_progress: %0d transfers required at least 200", accepts);
    end
    clear_reqs();
    avm_readdatavalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fifo_full();
    test_interleaved();
    test_orphan();
    test_reset_mid_issue();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
